// File: rtl/adder_if.sv
// Handshake/operand bundle for adder_pipe_nb.
// The ovf signal exists only when ADDER_OVF_EN is defined.
interface adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] t;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;
`ifdef ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, k, t, cin, out_ready,
    input  in_ready, out_valid, s, ovf
  );
  modport slave (
    input  in_valid, k, t, cin, out_ready,
    output in_ready, out_valid, s, ovf
  );
`else
  modport master (
    output in_valid, k, t, cin, out_ready,
    input  in_ready, out_valid, s
  );
  modport slave (
    input  in_valid, k, t, cin, out_ready,
    output in_ready, out_valid, s
  );
`endif
endinterface

// File: rtl/adder_pipe_nb.sv
// Pipelined WIDTH-bit adder with carry-in and valid/ready handshake.
// The add is split into STAGES chunks of CW = WIDTH/STAGES bits; one chunk is
// resolved per stage with the chunk carry registered in between.
// Optional feature: define ADDER_OVF_EN to add the registered signed-overflow
// output ovf.
// WIDTH must be >= 2 and divisible by STAGES; STAGES must be >= 1.
module adder_pipe_nb #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic   clk,
  input  logic   reset,
  adder_if.slave bus
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // One CW-bit chunk of the ripple add, carry out in the top bit.
  function automatic logic [CW:0] add_chunk(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          ci);
    add_chunk = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
  endfunction

  logic             en;
  logic             vld_p [STAGES];
  logic             c_p   [STAGES];
  logic [WIDTH-1:0] sum_p [STAGES];
  // Operand bits not yet consumed, shifted down so chunk i+1 sits at [CW-1:0].
  logic [WIDTH-1:0] k_p   [STAGES];
  logic [WIDTH-1:0] t_p   [STAGES];
  logic [CW:0]      cs    [STAGES];

  // The whole pipe advances together; a full output stage blocks it.
  assign en = bus.out_ready | ~vld_p[LAST];

  // Chunk adders: stage 0 takes the live operands, later stages the carried ones.
  always_comb begin
    cs[0] = add_chunk(bus.k[CW-1:0], bus.t[CW-1:0], bus.cin);
    for (int i = 1; i < STAGES; i++) begin
      cs[i] = add_chunk(k_p[i-1][CW-1:0], t_p[i-1][CW-1:0], c_p[i-1]);
    end
  end

  // ---- stage boundaries: data registers, advance only on en ----
  always_ff @(posedge clk) begin
    if (en) begin
      sum_p[0]         <= '0;
      sum_p[0][CW-1:0] <= cs[0][CW-1:0];
      c_p[0]           <= cs[0][CW];
      if (STAGES > 1) begin
        k_p[0] <= bus.k >> CW;
        t_p[0] <= bus.t >> CW;
      end
      for (int i = 1; i < STAGES - 1; i++) begin
        k_p[i] <= k_p[i-1] >> CW;
        t_p[i] <= t_p[i-1] >> CW;
      end
      for (int i = 1; i < STAGES; i++) begin
        sum_p[i]              <= sum_p[i-1];
        sum_p[i][i*CW +: CW]  <= cs[i][CW-1:0];
        c_p[i]                <= cs[i][CW];
      end
    end
  end

  // Valid bits: cleared by reset, otherwise shifted with the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
    end else if (en) begin
      vld_p[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = vld_p[LAST];
  // Data registers carry no reset, so the result is forced to zero when empty.
  assign bus.s         = vld_p[LAST] ? {c_p[LAST], sum_p[LAST]} : '0;

`ifdef ADDER_OVF_EN
  // Signed overflow: operands agree in sign, result sign differs.
  function automatic logic ovf_of(input logic ks, input logic ts, input logic ss);
    ovf_of = (ks == ts) & (ss != ks);
  endfunction

  logic km_p [STAGES];
  logic tm_p [STAGES];

  // Operand sign bits ride along with their transaction.
  always_ff @(posedge clk) begin
    if (en) begin
      km_p[0] <= bus.k[WIDTH-1];
      tm_p[0] <= bus.t[WIDTH-1];
      for (int i = 1; i < STAGES; i++) begin
        km_p[i] <= km_p[i-1];
        tm_p[i] <= tm_p[i-1];
      end
    end
  end

  assign bus.ovf = vld_p[LAST] & ovf_of(km_p[LAST], tm_p[LAST], sum_p[LAST][WIDTH-1]);
`endif

endmodule

// File: tb/tb_adder_pipe_nb.sv
// Directed and randomised bench for adder_pipe_nb: an 8-bit/2-stage instance
// for hand-written vectors and corner sequences, plus 16-bit instances with
// STAGES = 1, 4 and 16 under shared random traffic against a queue model.
module tb_adder_pipe_nb;

  logic clk;
  logic reset;
  int   cmp;
  int   err;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_if #(.WIDTH(8))  m ();
  adder_if #(.WIDTH(16)) w1 ();
  adder_if #(.WIDTH(16)) w4 ();
  adder_if #(.WIDTH(16)) w16 ();

  adder_pipe_nb #(.WIDTH(8),  .STAGES(2))  u_main (.clk(clk), .reset(reset), .bus(m));
  adder_pipe_nb #(.WIDTH(16), .STAGES(1))  u_s1   (.clk(clk), .reset(reset), .bus(w1));
  adder_pipe_nb #(.WIDTH(16), .STAGES(4))  u_s4   (.clk(clk), .reset(reset), .bus(w4));
  adder_pipe_nb #(.WIDTH(16), .STAGES(16)) u_s16  (.clk(clk), .reset(reset), .bus(w16));

  // Shared random stimulus for the sweep instances
  logic        rv;
  logic [15:0] rk;
  logic [15:0] rt;
  logic        rc;
  logic        rrdy;
  logic        mon_on;
  logic        lat_ph;

  assign w1.in_valid  = rv;  assign w1.k  = rk; assign w1.t  = rt; assign w1.cin  = rc; assign w1.out_ready  = rrdy;
  assign w4.in_valid  = rv;  assign w4.k  = rk; assign w4.t  = rt; assign w4.cin  = rc; assign w4.out_ready  = rrdy;
  assign w16.in_valid = rv;  assign w16.k = rk; assign w16.t = rt; assign w16.cin = rc; assign w16.out_ready = rrdy;

  logic        ov [3];
  logic        ir [3];
  logic [16:0] sw [3];
  assign ov[0] = w1.out_valid;  assign ir[0] = w1.in_ready;  assign sw[0] = w1.s;
  assign ov[1] = w4.out_valid;  assign ir[1] = w4.in_ready;  assign sw[1] = w4.s;
  assign ov[2] = w16.out_valid; assign ir[2] = w16.in_ready; assign sw[2] = w16.s;

  typedef struct {
    logic [16:0] s;
    int          st;
    logic        lat;
  } exp_t;
  exp_t q [3][$];
  int   stg [3] = '{1, 4, 16};

  typedef struct {
    logic [7:0] k;
    logic [7:0] t;
    logic       cin;
    logic [8:0] s;
    logic       ovf;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Sweep scoreboard: inputs/outputs observed mid-cycle, transfers happen at the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        for (int j = 0; j < 3; j++) begin
          if (ov[j] && rrdy) begin
            chk($sformatf("sweep%0d_pending", stg[j]), 32'(q[j].size() != 0), 32'd1);
            if (q[j].size() != 0) begin
              e = q[j].pop_front();
              chk($sformatf("sweep%0d_sum", stg[j]), 32'(sw[j]), 32'(e.s));
              if (e.lat) chk($sformatf("sweep%0d_lat", stg[j]), 32'(cyc - e.st), 32'(stg[j]));
            end
          end
          if (rv && ir[j]) begin
            e.s   = {1'b0, rk} + {1'b0, rt} + {16'd0, rc};
            e.st  = cyc;
            e.lat = lat_ph;
            q[j].push_back(e);
          end
        end
      end
    end
  end

  // One operand pair through the 8-bit pipe with out_ready=1; checks exact latency.
  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    m.in_valid = 1'b1; m.k = v.k; m.t = v.t; m.cin = v.cin; m.out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_in_ready", idx), 32'(m.in_ready), 32'd1);
    @(posedge clk); #1;
    m.in_valid = 1'b0; m.k = 8'h5A; m.t = 8'hC3; m.cin = ~v.cin;
    @(negedge clk);
    chk($sformatf("v%0d_not_early", idx), 32'(m.out_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_valid", idx), 32'(m.out_valid), 32'd1);
    chk($sformatf("v%0d_sum", idx), 32'(m.s), 32'(v.s));
`ifdef ADDER_OVF_EN
    chk($sformatf("v%0d_ovf", idx), 32'(m.ovf), 32'(v.ovf));
`endif
  endtask

  initial begin
    cmp = 0; err = 0;
    mon_on = 1'b0; lat_ph = 1'b0;
    rv = 1'b0; rk = '0; rt = '0; rc = 1'b0; rrdy = 1'b1;
    m.in_valid = 1'b0; m.k = '0; m.t = '0; m.cin = 1'b0; m.out_ready = 1'b1;

    vt[0] = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
    vt[1] = '{8'h00, 8'h00, 1'b1, 9'h001, 1'b0};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0};
    vt[3] = '{8'h12, 8'h34, 1'b0, 9'h046, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
    vt[5] = '{8'h0F, 8'h0F, 1'b0, 9'h01E, 1'b0};
    vt[6] = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1};
    vt[7] = '{8'hAA, 8'h55, 1'b1, 9'h100, 1'b0};

    // Reset state
    reset = 1'b1;
    m.in_valid = 1'b1; m.k = 8'hFF; m.t = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(m.out_valid), 32'd0);
    chk("rst_s", 32'(m.s), 32'd0);
    chk("rst_in_ready", 32'(m.in_ready), 32'd1);
`ifdef ADDER_OVF_EN
    chk("rst_ovf", 32'(m.ovf), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0; m.in_valid = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Back-to-back accept, 3-cycle stall, release with a simultaneous new input
    @(posedge clk); #1;
    m.in_valid = 1'b1; m.k = 8'h12; m.t = 8'h34; m.cin = 1'b0; m.out_ready = 1'b0;
    @(posedge clk); #1;
    m.k = 8'h80; m.t = 8'h80;
    @(posedge clk); #1;
    m.k = 8'h01; m.t = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), 32'(m.out_valid), 32'd1);
      chk($sformatf("bp_hold_s%0d", i), 32'(m.s), 32'h046);
      chk($sformatf("bp_hold_ready%0d", i), 32'(m.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    m.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_s0", 32'(m.s), 32'h046);
    chk("bp_rel_ready", 32'(m.in_ready), 32'd1);
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_rel_valid1", 32'(m.out_valid), 32'd1);
    chk("bp_rel_s1", 32'(m.s), 32'h100);
    @(negedge clk);
    chk("bp_rel_valid2", 32'(m.out_valid), 32'd1);
    chk("bp_rel_s2", 32'(m.s), 32'h002);
    @(negedge clk);
    chk("bp_drained", 32'(m.out_valid), 32'd0);

    // Reset with an operand pair in flight
    @(posedge clk); #1;
    m.in_valid = 1'b1; m.k = 8'h0F; m.t = 8'h01; m.cin = 1'b0;
    @(posedge clk); #1;
    m.in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", 32'(m.out_valid), 32'd0);
    chk("rstmid_s", 32'(m.s), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_none%0d", i), 32'(m.out_valid), 32'd0);
    end

    // Random sweep: first with out_ready=1 (latency checked), then random out_ready
    mon_on = 1'b1; lat_ph = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
      rv = ($urandom_range(3) != 0); rk = 16'($urandom); rt = 16'($urandom);
      rc = 1'($urandom); rrdy = 1'b1;
    end
    @(posedge clk); #1;
    rv = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    lat_ph = 1'b0;
    repeat (2000) begin
      @(posedge clk); #1;
      rv = ($urandom_range(3) != 0);
      rk = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      rt = 16'($urandom); rc = 1'($urandom);
      rrdy = 1'($urandom);
    end
    @(posedge clk); #1;
    rv = 1'b0; rrdy = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    mon_on = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("sweep%0d_drained", stg[j]), 32'(q[j].size()), 32'd0);
      chk($sformatf("sweep%0d_idle", stg[j]), 32'(ov[j]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
